// File: rtl/fp32_addtree8to1_sequencer_pkg.sv
// Shared constants and FSM state type for the FP32 8:1 adder-tree sequencer.
package fp32_addtree8to1_sequencer_pkg;

    localparam int unsigned FP32_WIDTH = 32;
    localparam int unsigned NUM_INPUTS = 8;
    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned SLOT_W     = 16;

    // -0 is the additive identity, so padded slots keep an all -0 sum at -0.
    localparam logic [FP32_WIDTH-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fp32_addtree8to1_sequencer.sv
// Groups an FP32 operand stream eight at a time onto the adder-tree S0/S1 buses,
// issues the CRU command, and packs four lane results into one 128-bit packet.
module fp32_addtree8to1_sequencer
    import fp32_addtree8to1_sequencer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic [127:0] dvr_fp32addtree8to1_s0,
    output logic [127:0] dvr_fp32addtree8to1_s1,
    output logic [2:0]   cru_fp32addtree8to1,
    input  logic [127:0] dr_fp32addtree8to1_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   out_lane_mask
);

    state_t         r_state;
    logic [2:0]     r_slot_cnt;
    logic [1:0]     r_lane_cnt;
    logic           r_last_seen;
    logic [127:0]   r_s0;
    logic [127:0]   r_s1;
    logic [127:0]   r_out_data;
    logic [3:0]     r_lane_mask;
    logic           r_out_valid;

    logic           w_accept;
    logic           w_group_done;
    logic [31:0]    w_lane_result;

    assign in_ready      = (r_state == ST_FILL);
    assign w_accept      = in_valid && in_ready;
    assign w_group_done  = w_accept && ((r_slot_cnt == 3'd7) || in_last);
    assign w_lane_result = dr_fp32addtree8to1_d[32*r_lane_cnt +: 32];

    assign cru_fp32addtree8to1    = (r_state == ST_ISSUE) ? {1'b1, r_lane_cnt} : 3'b000;
    assign dvr_fp32addtree8to1_s0 = r_s0;
    assign dvr_fp32addtree8to1_s1 = r_s1;
    assign out_valid              = r_out_valid;
    assign out_data               = r_out_data;
    assign out_lane_mask          = r_lane_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_slot_cnt  <= '0;
            r_lane_cnt  <= '0;
            r_last_seen <= 1'b0;
            r_s0        <= '0;
            r_s1        <= '0;
            r_out_data  <= '0;
            r_lane_mask <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        // Current slot takes the operand; on an early in_last the slots above it are padded in the same edge.
                        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
                            if (k == 32'(r_slot_cnt)) begin
                                r_s0[SLOT_W*k +: SLOT_W] <= in_data[15:0];
                                r_s1[SLOT_W*k +: SLOT_W] <= in_data[31:16];
                            end else if (in_last && (k > 32'(r_slot_cnt))) begin
                                r_s0[SLOT_W*k +: SLOT_W] <= PAD_WORD[15:0];
                                r_s1[SLOT_W*k +: SLOT_W] <= PAD_WORD[31:16];
                            end
                        end
                        if (w_group_done) begin
                            r_slot_cnt  <= '0;
                            r_last_seen <= in_last;
                            r_state     <= ST_ISSUE;
                        end else begin
                            r_slot_cnt <= r_slot_cnt + 3'd1;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_out_data[32*r_lane_cnt +: 32] <= w_lane_result;
                    r_lane_mask[r_lane_cnt]         <= 1'b1;
                    if ((r_lane_cnt == 2'd3) || r_last_seen) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_lane_cnt <= r_lane_cnt + 2'd1;
                        r_state    <= ST_FILL;
                    end
                end

                ST_DRAIN: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_lane_mask <= '0;
                        r_lane_cnt  <= '0;
                        r_last_seen <= 1'b0;
                        r_state     <= ST_FILL;
                    end
                end

                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_addtree8to1_sequencer.sv
// Directed bench for fp32_addtree8to1_sequencer with a behavioural 8:1 FP32 adder-tree model on dr_d.
module tb_fp32_addtree8to1_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [127:0] s0;
    logic [127:0] s1;
    logic [2:0]   cru;
    logic [127:0] dr_d;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_lane_mask;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]   cru_log[$];
    logic [127:0] snap_s0;
    logic [127:0] snap_s1;

    fp32_addtree8to1_sequencer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_data                (in_data),
        .in_last                (in_last),
        .dvr_fp32addtree8to1_s0 (s0),
        .dvr_fp32addtree8to1_s1 (s1),
        .cru_fp32addtree8to1    (cru),
        .dr_fp32addtree8to1_d   (dr_d),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_data               (out_data),
        .out_lane_mask          (out_lane_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        e = int'(b[30:23]) - 127;
        v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** e);
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        real         a;
        int          e;
        logic [22:0] m;
        if (x == 0.0) return 32'h0;
        a = (x < 0.0) ? -x : x;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {(x < 0.0), 8'(e), m};
    endfunction

    function automatic logic [31:0] tree_sum(input logic [127:0] a0, input logic [127:0] a1);
        logic [31:0] op;
        real         acc;
        bit          all_zero;
        bit          all_neg;
        acc = 0.0;
        all_zero = 1'b1;
        all_neg  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = {a1[16*k +: 16], a0[16*k +: 16]};
            if (op[30:0] != 31'd0) all_zero = 1'b0;
            if (!op[31]) all_neg = 1'b0;
            acc = acc + f2r(op);
        end
        if (all_zero) return all_neg ? 32'h8000_0000 : 32'h0;
        return r2f(acc);
    endfunction

    // Non-selected lanes carry junk so a wrong lane pick shows up.
    always_comb begin
        dr_d = {4{32'hDEAD_BEEF}};
        if (cru[2]) dr_d[32*cru[1:0] +: 32] = tree_sum(s0, s1);
    end

    always @(negedge clk) begin
        if (cru[2]) begin
            cru_log.push_back(cru);
            snap_s0 = s0;
            snap_s1 = s1;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0 || out_lane_mask !== 4'h0) begin
            n_fail++; $display("FAIL reset_out: valid=%b mask=%h want 0/0", out_valid, out_lane_mask);
        end
        n_tests++;
        if (out_data !== 128'h0 || s0 !== 128'h0 || s1 !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: out=%h s0=%h s1=%h want 0", out_data, s0, s1);
        end
        n_tests++;
        if (cru !== 3'b000) begin n_fail++; $display("FAIL reset_cru: got %b want 000", cru); end
    endtask

    task automatic test_full_group();
        cru_log.delete();
        for (int i = 0; i < 8; i++) send_word(32'h3F80_0000, i == 7);
        n_tests++;
        if (cru !== 3'b100 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_issue: cru=%b valid=%b rdy=%b want 100/0/0", cru, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || cru !== 3'b000) begin
            n_fail++; $display("FAIL full_valid_rise: valid=%b cru=%b want 1/000", out_valid, cru);
        end
        n_tests++;
        if (snap_s0 !== 128'h0 || snap_s1 !== {8{16'h3F80}}) begin
            n_fail++; $display("FAIL full_slots: s0=%h s1=%h", snap_s0, snap_s1);
        end
        n_tests++;
        if (cru_log.size() != 1) begin n_fail++; $display("FAIL full_cru_count: got %0d want 1", cru_log.size()); end
        n_tests++;
        if (out_data !== 128'h4100_0000 || out_lane_mask !== 4'b0001) begin
            n_fail++; $display("FAIL full_result: data=%h mask=%b want 41000000/0001", out_data, out_lane_mask);
        end
        handshake();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || out_lane_mask !== 4'h0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_drain: valid=%b data=%h mask=%h rdy=%b", out_valid, out_data, out_lane_mask, in_ready);
        end
    endtask

    task automatic test_four_lanes();
        logic [31:0] vals [4];
        vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
        cru_log.delete();
        for (int g = 0; g < 4; g++)
            for (int i = 0; i < 8; i++) send_word(vals[g], (g == 3) && (i == 7));
        wait_out();
        n_tests++;
        if (out_data !== {32'h4200_0000, 32'h41C0_0000, 32'h4180_0000, 32'h4100_0000} || out_lane_mask !== 4'hF) begin
            n_fail++; $display("FAIL four_result: data=%h mask=%h", out_data, out_lane_mask);
        end
        n_tests++;
        if (cru_log.size() != 4 || cru_log[0] !== 3'b100 || cru_log[1] !== 3'b101 ||
            cru_log[2] !== 3'b110 || cru_log[3] !== 3'b111) begin
            n_fail++; $display("FAIL four_cru_seq: count=%0d want 100,101,110,111", cru_log.size());
        end
        handshake();
    endtask

    task automatic test_padding();
        cru_log.delete();
        for (int i = 0; i < 3; i++) send_word(32'h3F80_0000, i == 2);
        wait_out();
        n_tests++;
        if (snap_s1 !== {{5{16'h8000}}, {3{16'h3F80}}} || snap_s0 !== 128'h0) begin
            n_fail++; $display("FAIL pad_slots: s0=%h s1=%h", snap_s0, snap_s1);
        end
        n_tests++;
        if (out_data !== 128'h4040_0000 || out_lane_mask !== 4'b0001) begin
            n_fail++; $display("FAIL pad_result: data=%h mask=%b want 40400000/0001", out_data, out_lane_mask);
        end
        handshake();
    endtask

    task automatic test_neg_zero();
        send_word(32'h8000_0000, 1'b1);
        wait_out();
        n_tests++;
        if (out_data !== 128'h8000_0000 || out_lane_mask !== 4'b0001) begin
            n_fail++; $display("FAIL negzero_result: data=%h mask=%b want 80000000/0001", out_data, out_lane_mask);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [127:0] held;
        for (int i = 0; i < 8; i++) send_word(32'h4000_0000, i == 7);
        wait_out();
        held = out_data;
        n_tests++;
        if (held !== 128'h4180_0000) begin n_fail++; $display("FAIL bp_result: data=%h want 41800000", held); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held || out_lane_mask !== 4'b0001) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: valid=%b rdy=%b data=%h mask=%b", c, out_valid, in_ready, out_data, out_lane_mask);
            end
        end
        handshake();
        cru_log.delete();
        for (int i = 0; i < 8; i++) send_word(32'h3F80_0000, 1'b0);
        send_word(32'h3F80_0000, 1'b1);
        wait_out();
        n_tests++;
        if (cru_log.size() != 2 || cru_log[0] !== 3'b100 || cru_log[1] !== 3'b101) begin
            n_fail++; $display("FAIL bp_next_lane0: cru count=%0d want 100,101", cru_log.size());
        end
        n_tests++;
        if (out_data !== {64'h0, 32'h3F80_0000, 32'h4100_0000} || out_lane_mask !== 4'b0011) begin
            n_fail++; $display("FAIL bp_next_result: data=%h mask=%b want 3f800000_41000000/0011", out_data, out_lane_mask);
        end
        handshake();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) send_word(32'h3F80_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_lane_mask !== 4'h0 || cru !== 3'b000 ||
            s0 !== 128'h0 || s1 !== 128'h0 || out_data !== 128'h0) begin
            n_fail++; $display("FAIL midreset_state: rdy=%b valid=%b mask=%h cru=%b s1=%h", in_ready, out_valid, out_lane_mask, cru, s1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_word(32'h4040_0000, i == 7);
        wait_out();
        n_tests++;
        if (snap_s1 !== {8{16'h4040}} || snap_s0 !== 128'h0) begin
            n_fail++; $display("FAIL midreset_slots: s0=%h s1=%h", snap_s0, snap_s1);
        end
        n_tests++;
        if (out_data !== 128'h41C0_0000 || out_lane_mask !== 4'b0001) begin
            n_fail++; $display("FAIL midreset_result: data=%h mask=%b want 41c00000/0001", out_data, out_lane_mask);
        end
        handshake();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_full_group();
        test_four_lanes();
        test_padding();
        test_neg_zero();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
